multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Multi-cycle control sequencer for the RV32I data path; replaces static per-test control driving.
//  Decodes the fetched instruction and steps FETCH->DECODE->EXEC->MEM->WB.
//  Drives data_path controls (en_pc, RegWrite, AluSrc, AluSel, Mem_read, Mem_write, sel_data_to_reg).
//  Handshakes with instruction and data memories that may insert wait states.
// PARAMETERS
//  ALUSEL_W      4   width of AluSel
//  SEL_W         2   width of sel_data_to_reg
//  DMEM_TIMEOUT  16  max cycles waiting dmem_ready before bus error; 0 = wait forever
// PORTS
//  clk              in   1         single clock, rising edge
//  reset            in   1         synchronous, active-high
//  instr            in   32        instruction word, valid when imem_ready=1
//  imem_ready       in   1         instruction memory returns instr this cycle
//  dmem_ready       in   1         data access completes this cycle
//  hold             in   1         freeze sequencer (external stall)
//  imem_req         out  1         fetch request
//  ir_load          out  1         latch instr into IR (1-cycle pulse)
//  en_pc            out  1         PC <= PC+4 (1-cycle pulse, WB only)
//  RegWrite         out  1         register-file write strobe (WB only)
//  AluSrc           out  1         0 = rs2, 1 = immediate
//  AluSel           out  ALUSEL_W  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  Mem_read         out  1         load in progress
//  Mem_write        out  1         store in progress
//  sel_data_to_reg  out  SEL_W     0 mem data,1 ALU,2 PC+4,3 U-imm
//  retire           out  1         instruction completed (1-cycle pulse)
//  bus_err          out  1         sticky: dmem timeout occurred
//  state_o          out  3         current FSM state (debug)
// BEHAVIOUR
//  Reset: state=FETCH; all outputs 0, including bus_err and decoded control regs.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
//  FETCH: imem_req=1 until imem_ready; on imem_ready: ir_load=1 that cycle, instr latched -> DECODE.
//  DECODE (1 cycle): opcode instr[6:0] registered into controls; next state:
//   0110011 R   -> EXEC, AluSrc=0, AluSel from funct3/funct7[5], sel=1
//   0010011 I   -> EXEC, AluSrc=1, AluSel from funct3 (funct7[5] only for SRAI), sel=1
//   0000011 LD  -> EXEC, AluSrc=1, AluSel=ADD, sel=0
//   0100011 ST  -> EXEC, AluSrc=1, AluSel=ADD, no reg write
//   0110111 LUI -> WB,   sel=3
//   other: illegal (see CONFIGURATION)
//  EXEC (1 cycle): LD/ST -> MEM; R/I -> WB.
//  MEM: Mem_read (LD) or Mem_write (ST) held high until dmem_ready; then -> WB.
//   Wait counter resets on MEM entry; if DMEM_TIMEOUT!=0 and count reaches DMEM_TIMEOUT without ready:
//   bus_err<=1, drop Mem_*, -> FETCH, no writeback, no en_pc, no retire.
//  WB (1 cycle): RegWrite=1 for R/I/LD/LUI (0 for ST); en_pc=1; retire=1 -> FETCH.
//  AluSrc/AluSel/sel_data_to_reg valid from EXEC through WB; don't-care elsewhere.
//  Latency with zero-wait memories: LUI 3, R/I 4, ST/LD 5 cycles.
//  hold=1: state, counters, and registered controls frozen.
//   Pulse outputs (ir_load, en_pc, RegWrite, retire) forced 0; level outputs (imem_req, Mem_*) kept.
//   imem_ready/dmem_ready ignored while hold=1.
//  reset mid-instruction: abort immediately to FETCH; no pulse issued in the reset cycle.
//  x0 writes are not filtered here (register file ignores rd=0).
// CONFIGURATION
//  MULTI_CYCLE_CTRL_TRAP_EN defined:
//   illegal opcode in DECODE -> TRAP; TRAP is terminal (only reset exits); all strobes 0; state_o=5.
//  Not defined:
//   illegal opcode treated as NOP: DECODE -> WB with RegWrite=0, en_pc=1, retire=1.
// TESTING
//  1 addi x1,x0,10 (0x00A00093), zero-wait -> ir_load@FETCH; AluSrc=1,AluSel=0,sel=1 in EXEC/WB; RegWrite+en_pc in cycle 4.
//  2 lui x5,0xABCDE (0xABCDE2B7) -> no EXEC; sel=3, RegWrite=1, retire in cycle 3.
//  3 or x20,x1,x5 (0x0050EA33) -> AluSrc=0, AluSel=3, RegWrite in WB.
//  4 sw x20,0(x1) (0x0140A023), dmem_ready after 3 waits -> Mem_write high 4 cycles; WB RegWrite=0, en_pc=1.
//  5 lw, dmem_ready never, DMEM_TIMEOUT=16 -> bus_err=1 after 16 MEM cycles; back to FETCH; no retire.
//  6 hold=1 for 3 cycles during WB, then reset during MEM -> no en_pc while held; single en_pc after release; reset -> FETCH, outputs 0.
//  7 opcode 0x7F -> TRAP with MULTI_CYCLE_CTRL_TRAP_EN; otherwise NOP retire with RegWrite=0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if
//   Groups the memory handshakes and datapath control strobes of the RV32I
//   multi-cycle sequencer.
//
//   master : the sequencer (drives requests and datapath controls)
//   slave  : memories + datapath (return instr/ready, consume controls)
//
//   instr            32        instruction word, valid when imem_ready=1
//   imem_ready       1         instruction memory returns instr this cycle
//   dmem_ready       1         data access completes this cycle
//   imem_req         1         fetch request
//   ir_load          1         latch instr into IR (1-cycle pulse)
//   en_pc            1         PC <= PC+4 (1-cycle pulse)
//   RegWrite         1         register-file write strobe
//   AluSrc           1         0 = rs2, 1 = immediate
//   AluSel           ALUSEL_W  ALU operation select
//   Mem_read         1         load in progress
//   Mem_write        1         store in progress
//   sel_data_to_reg  SEL_W     writeback mux select
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if #(
    parameter int unsigned ALUSEL_W = 4,
    parameter int unsigned SEL_W    = 2
);
    logic [31:0]         instr;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_load;
    logic                en_pc;
    logic                RegWrite;
    logic                AluSrc;
    logic [ALUSEL_W-1:0] AluSel;
    logic                Mem_read;
    logic                Mem_write;
    logic [SEL_W-1:0]    sel_data_to_reg;

    modport master (
        input  instr, imem_ready, dmem_ready,
        output imem_req, ir_load, en_pc, RegWrite, AluSrc, AluSel,
               Mem_read, Mem_write, sel_data_to_reg
    );

    modport slave (
        output instr, imem_ready, dmem_ready,
        input  imem_req, ir_load, en_pc, RegWrite, AluSrc, AluSel,
               Mem_read, Mem_write, sel_data_to_reg
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle control sequencer for the RV32I data path. Fetches an
//   instruction, decodes it and steps FETCH -> DECODE -> EXEC -> MEM -> WB,
//   driving the datapath controls and handshaking with instruction and data
//   memories that may insert wait states.
//
//   Optional feature macro: MULTI_CYCLE_CTRL_TRAP_EN
//     defined     : illegal opcode -> terminal TRAP state (only reset exits)
//     not defined : illegal opcode retires as a NOP (no register write)
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; aborts to FETCH
//   hold     in   freezes the sequencer; pulse outputs forced low
//   bus      -    multi_cycle_ctrl_if.master (memory handshakes, controls)
//   retire   out  instruction completed (1-cycle pulse)
//   bus_err  out  sticky: data memory timeout occurred
//   state_o  out  current FSM state (debug)
//
// Parameters
//   ALUSEL_W      width of AluSel
//   SEL_W         width of sel_data_to_reg
//   DMEM_TIMEOUT  max MEM cycles without dmem_ready before bus error;
//                 0 = wait forever
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int unsigned ALUSEL_W     = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned DMEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    multi_cycle_ctrl_if.master  bus,
    output logic                retire,
    output logic                bus_err,
    output logic [2:0]          state_o
);

    // FSM encodings (legacy-compatible numeric values, visible on state_o)
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [ALUSEL_W-1:0] ALU_ADD  = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] ALU_SUB  = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] ALU_AND  = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] ALU_OR   = ALUSEL_W'(3);
    localparam logic [ALUSEL_W-1:0] ALU_XOR  = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] ALU_SLL  = ALUSEL_W'(5);
    localparam logic [ALUSEL_W-1:0] ALU_SRL  = ALUSEL_W'(6);
    localparam logic [ALUSEL_W-1:0] ALU_SRA  = ALUSEL_W'(7);
    localparam logic [ALUSEL_W-1:0] ALU_SLT  = ALUSEL_W'(8);
    localparam logic [ALUSEL_W-1:0] ALU_SLTU = ALUSEL_W'(9);

    // Writeback mux: 0 mem data, 1 ALU, 2 PC+4 (unused here), 3 U-imm
    localparam logic [SEL_W-1:0] SEL_MEM  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_ALU  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_UIMM = SEL_W'(3);

    // Wait counter runs 0 .. DMEM_TIMEOUT-1
    localparam int unsigned CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]          state_q, state_d;

    // Only the instruction fields the sequencer needs are kept
    logic [6:0]          opcode_q;
    logic [2:0]          funct3_q;
    logic                bit30_q;

    logic                alu_src_q;
    logic [ALUSEL_W-1:0] alu_sel_q;
    logic [SEL_W-1:0]    sel_q;
    logic                is_load_q;
    logic                is_store_q;
    logic                reg_we_q;

    logic [CNT_W-1:0]    wait_cnt_q;
    logic                bus_err_q;

    logic                unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // ------------------------------------------------------------------
    // Decode of the latched instruction (used in DECODE)
    // ------------------------------------------------------------------
    function automatic logic [ALUSEL_W-1:0] alu_fn(
        input logic [2:0] f3,
        input logic       b30,
        input logic       is_r
    );
        logic [ALUSEL_W-1:0] sel;
        case (f3)
            // bit 30 is an immediate bit for ADDI, so SUB only for R-type
            3'b000:  sel = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    logic                dec_src;
    logic [ALUSEL_W-1:0] dec_alu;
    logic [SEL_W-1:0]    dec_sel;
    logic                dec_load;
    logic                dec_store;
    logic                dec_we;
    logic [2:0]          dec_next;

    always_comb begin
        dec_src   = 1'b0;
        dec_alu   = ALU_ADD;
        dec_sel   = SEL_MEM;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_we    = 1'b0;
        dec_next  = ST_EXEC;
        case (opcode_q)
            OP_R: begin
                dec_alu = alu_fn(funct3_q, bit30_q, 1'b1);
                dec_sel = SEL_ALU;
                dec_we  = 1'b1;
            end
            OP_I: begin
                dec_src = 1'b1;
                dec_alu = alu_fn(funct3_q, bit30_q, 1'b0);
                dec_sel = SEL_ALU;
                dec_we  = 1'b1;
            end
            OP_LD: begin
                dec_src  = 1'b1;
                dec_load = 1'b1;
                dec_we   = 1'b1;
            end
            OP_ST: begin
                dec_src   = 1'b1;
                dec_store = 1'b1;
            end
            OP_LUI: begin
                dec_sel  = SEL_UIMM;
                dec_we   = 1'b1;
                dec_next = ST_WB;
            end
            default: begin
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
                dec_next = ST_TRAP;
`else
                // Illegal opcode retires as a NOP: no register write
                dec_next = ST_WB;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    logic mem_timeout;
    assign mem_timeout = (DMEM_TIMEOUT != 0) && !bus.dmem_ready &&
                         (wait_cnt_q == CNT_W'(DMEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (bus.imem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_next;
            ST_EXEC:   state_d = (is_load_q || is_store_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.dmem_ready)   state_d = ST_WB;
                else if (mem_timeout) state_d = ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers: hold freezes everything, including memory-ready sampling
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            opcode_q   <= '0;
            funct3_q   <= '0;
            bit30_q    <= 1'b0;
            alu_src_q  <= 1'b0;
            alu_sel_q  <= '0;
            sel_q      <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            reg_we_q   <= 1'b0;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else if (!hold) begin
            state_q <= state_d;

            if (state_q == ST_FETCH && bus.imem_ready) begin
                opcode_q <= bus.instr[6:0];
                funct3_q <= bus.instr[14:12];
                bit30_q  <= bus.instr[30];
            end

            if (state_q == ST_DECODE) begin
                alu_src_q  <= dec_src;
                alu_sel_q  <= dec_alu;
                sel_q      <= dec_sel;
                is_load_q  <= dec_load;
                is_store_q <= dec_store;
                reg_we_q   <= dec_we;
            end

            // Counter is cleared outside MEM so every MEM entry starts at 0
            if (state_q == ST_MEM && !bus.dmem_ready) begin
                if (mem_timeout) begin
                    bus_err_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes are decoded from the state so that reset and hold
    // can suppress them in the same cycle they are asserted.
    // ------------------------------------------------------------------
    logic active;
    logic pulse_ok;
    assign active   = !reset;
    assign pulse_ok = !reset && !hold;

    assign bus.imem_req        = active && (state_q == ST_FETCH);
    assign bus.ir_load         = pulse_ok && (state_q == ST_FETCH) && bus.imem_ready;
    assign bus.en_pc           = pulse_ok && (state_q == ST_WB);
    assign bus.RegWrite        = pulse_ok && (state_q == ST_WB) && reg_we_q;
    assign bus.Mem_read        = active && (state_q == ST_MEM) && is_load_q;
    assign bus.Mem_write       = active && (state_q == ST_MEM) && is_store_q;
    assign bus.AluSrc          = alu_src_q;
    assign bus.AluSel          = alu_sel_q;
    assign bus.sel_data_to_reg = sel_q;

    assign retire  = pulse_ok && (state_q == ST_WB);
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed self-checking bench for multi_cycle_ctrl. Inputs change in the
//   low clock phase and outputs are sampled 1 ns later, before the next
//   rising edge. Strobes are compared as one packed word:
//   {state_o[2:0], imem_req, ir_load, en_pc, RegWrite, retire, Mem_read, Mem_write}
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       retire;
    logic       bus_err;
    logic [2:0] state_o;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl_if #(.ALUSEL_W(4), .SEL_W(2)) bus ();

    multi_cycle_ctrl #(
        .ALUSEL_W    (4),
        .SEL_W       (2),
        .DMEM_TIMEOUT(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .bus    (bus),
        .retire (retire),
        .bus_err(bus_err),
        .state_o(state_o)
    );

    function automatic logic [9:0] strobes();
        return {state_o, bus.imem_req, bus.ir_load, bus.en_pc, bus.RegWrite,
                retire, bus.Mem_read, bus.Mem_write};
    endfunction

    function automatic logic [6:0] ctrls();
        return {bus.AluSrc, bus.AluSel, bus.sel_data_to_reg};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00A00093;
    localparam logic [31:0] I_LUI  = 32'hABCDE2B7;
    localparam logic [31:0] I_SW   = 32'h0140A023;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; hold = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        @(negedge clk); @(negedge clk); #1;
        exp = {3'd0, 7'b0000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL reset_strobes: got %b expected %b", strobes(), exp); end
        tests++;
        if (ctrls() !== 7'd0 || bus_err !== 1'b0) begin
            fails++; $display("FAIL reset_ctrls: got ctrl=%b bus_err=%b expected 0/0", ctrls(), bus_err);
        end
        reset = 1'b0; #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL reset_release: got %b expected %b", strobes(), exp); end
    endtask

    task automatic test_addi();
        logic [9:0] exp;
        bus.instr = I_ADDI; bus.imem_ready = 1'b1; #1;
        exp = {3'd0, 7'b1100000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL addi_fetch: got %b expected %b", strobes(), exp); end
        @(negedge clk); bus.imem_ready = 1'b0; bus.instr = '0; #1;
        exp = {3'd1, 7'b0000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL addi_decode: got %b expected %b", strobes(), exp); end
        @(negedge clk); #1;
        tests++;
        if (state_o !== 3'd2 || ctrls() !== {1'b1, 4'd0, 2'd1}) begin
            fails++; $display("FAIL addi_exec: got state=%0d ctrl=%b expected 2/%b", state_o, ctrls(), {1'b1, 4'd0, 2'd1});
        end
        @(negedge clk); #1;
        exp = {3'd4, 7'b0011100};
        tests++;
        if (strobes() !== exp || ctrls() !== {1'b1, 4'd0, 2'd1}) begin
            fails++; $display("FAIL addi_wb: got %b ctrl=%b expected %b ctrl=%b", strobes(), ctrls(), exp, {1'b1, 4'd0, 2'd1});
        end
        @(negedge clk); #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL addi_refetch: got %b expected %b", strobes(), exp); end
    endtask

    // One imem wait state, then LUI skips EXEC
    task automatic test_lui();
        logic [9:0] exp;
        bus.imem_ready = 1'b0; bus.instr = I_LUI; #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL lui_imem_wait: got %b expected %b", strobes(), exp); end
        @(negedge clk); bus.imem_ready = 1'b1; #1;
        exp = {3'd0, 7'b1100000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL lui_fetch: got %b expected %b", strobes(), exp); end
        @(negedge clk); bus.imem_ready = 1'b0; #1;
        @(negedge clk); #1;
        exp = {3'd4, 7'b0011100};
        tests++;
        if (strobes() !== exp || bus.sel_data_to_reg !== 2'd3) begin
            fails++; $display("FAIL lui_wb: got %b sel=%0d expected %b sel=3", strobes(), bus.sel_data_to_reg, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_alu_decode();
        logic [31:0] tbl_instr [6] = '{32'h0050EA33, 32'h402081B3, 32'h4030D093,
                                       32'hC0000093, 32'h0030D093, 32'h0020A1B3};
        logic [3:0]  tbl_alu   [6] = '{4'd3, 4'd1, 4'd7, 4'd0, 4'd6, 4'd8};
        logic        tbl_src   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [9:0]  exp;
        logic [6:0]  expc;
        for (int k = 0; k < 6; k++) begin
            bus.instr = tbl_instr[k]; bus.imem_ready = 1'b1;
            @(negedge clk); bus.imem_ready = 1'b0; bus.instr = '0;
            @(negedge clk); #1;
            expc = {tbl_src[k], tbl_alu[k], 2'd1};
            tests++;
            if (state_o !== 3'd2 || ctrls() !== expc) begin
                fails++; $display("FAIL alu_exec[%0d]: got state=%0d ctrl=%b expected 2/%b", k, state_o, ctrls(), expc);
            end
            @(negedge clk); #1;
            exp = {3'd4, 7'b0011100};
            tests++;
            if (strobes() !== exp) begin fails++; $display("FAIL alu_wb[%0d]: got %b expected %b", k, strobes(), exp); end
            @(negedge clk);
        end
    endtask

    // Three dmem wait states then ready: Mem_write high four cycles
    task automatic test_store_wait();
        logic [9:0] exp;
        bus.instr = I_SW; bus.imem_ready = 1'b1;
        @(negedge clk); bus.imem_ready = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (state_o !== 3'd2 || bus.Mem_write !== 1'b0 || ctrls() !== {1'b1, 4'd0, 2'd0}) begin
            fails++; $display("FAIL sw_exec: got state=%0d mw=%b ctrl=%b expected 2/0/%b", state_o, bus.Mem_write, ctrls(), {1'b1, 4'd0, 2'd0});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.dmem_ready = (i == 3); #1;
            exp = {3'd3, 7'b0000001};
            tests++;
            if (strobes() !== exp) begin fails++; $display("FAIL sw_mem[%0d]: got %b expected %b", i, strobes(), exp); end
        end
        @(negedge clk); bus.dmem_ready = 1'b0; #1;
        exp = {3'd4, 7'b0010100};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL sw_wb: got %b expected %b", strobes(), exp); end
        @(negedge clk);
    endtask

    // Ready arrives on the 16th MEM cycle: last chance before timeout
    task automatic test_load_boundary();
        logic [9:0] exp;
        bus.instr = I_LW; bus.imem_ready = 1'b1;
        @(negedge clk); bus.imem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); bus.dmem_ready = (i == 15); #1;
            exp = {3'd3, 7'b0000010};
            tests++;
            if (strobes() !== exp) begin fails++; $display("FAIL lw_edge_mem[%0d]: got %b expected %b", i, strobes(), exp); end
        end
        @(negedge clk); bus.dmem_ready = 1'b0; #1;
        exp = {3'd4, 7'b0011100};
        tests++;
        if (strobes() !== exp || ctrls() !== {1'b1, 4'd0, 2'd0} || bus_err !== 1'b0) begin
            fails++; $display("FAIL lw_edge_wb: got %b ctrl=%b err=%b expected %b ctrl=%b err=0", strobes(), ctrls(), bus_err, exp, {1'b1, 4'd0, 2'd0});
        end
        @(negedge clk);
    endtask

    task automatic test_load_timeout();
        logic [9:0] exp;
        bus.instr = I_LW; bus.imem_ready = 1'b1;
        @(negedge clk); bus.imem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            exp = {3'd3, 7'b0000010};
            tests++;
            if (strobes() !== exp || bus_err !== 1'b0) begin
                fails++; $display("FAIL lw_to_mem[%0d]: got %b err=%b expected %b err=0", i, strobes(), bus_err, exp);
            end
        end
        @(negedge clk); #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp || bus_err !== 1'b1) begin
            fails++; $display("FAIL lw_timeout: got %b err=%b expected %b err=1", strobes(), bus_err, exp);
        end
    endtask

    task automatic test_hold_reset();
        logic [9:0] exp;
        hold = 1'b1; bus.instr = I_ADDI; bus.imem_ready = 1'b1; #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL hold_fetch: got %b expected %b", strobes(), exp); end
        @(negedge clk); hold = 1'b0; #1;
        exp = {3'd0, 7'b1100000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL hold_fetch_release: got %b expected %b", strobes(), exp); end
        @(negedge clk); bus.imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = {3'd4, 7'b0000000};
            tests++;
            if (strobes() !== exp) begin fails++; $display("FAIL hold_wb[%0d]: got %b expected %b", i, strobes(), exp); end
            @(negedge clk);
        end
        hold = 1'b0; #1;
        exp = {3'd4, 7'b0011100};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL hold_wb_release: got %b expected %b", strobes(), exp); end
        @(negedge clk); #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL hold_single_enpc: got %b expected %b", strobes(), exp); end

        bus.instr = I_SW; bus.imem_ready = 1'b1;
        @(negedge clk); bus.imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        exp = {3'd3, 7'b0000001};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL rst_pre_mem: got %b expected %b", strobes(), exp); end
        reset = 1'b1; bus.dmem_ready = 1'b1; #1;
        exp = {3'd3, 7'b0000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL rst_cycle: got %b expected %b", strobes(), exp); end
        @(negedge clk); #1;
        exp = {3'd0, 7'b0000000};
        tests++;
        if (strobes() !== exp || ctrls() !== 7'd0 || bus_err !== 1'b0) begin
            fails++; $display("FAIL rst_abort: got %b ctrl=%b err=%b expected %b ctrl=0 err=0", strobes(), ctrls(), bus_err, exp);
        end
        reset = 1'b0; bus.dmem_ready = 1'b0; #1;
    endtask

    task automatic test_illegal();
        logic [9:0] exp;
        bus.instr = I_ILL; bus.imem_ready = 1'b1;
        @(negedge clk); bus.imem_ready = 1'b0; #1;
        tests++;
        if (state_o !== 3'd1) begin fails++; $display("FAIL ill_decode: got state=%0d expected 1", state_o); end
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        @(negedge clk); #1;
        exp = {3'd5, 7'b0000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL ill_trap: got %b expected %b", strobes(), exp); end
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL ill_trap_stuck: got %b expected %b", strobes(), exp); end
        do_reset();
`else
        @(negedge clk); #1;
        exp = {3'd4, 7'b0010100};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL ill_nop_wb: got %b expected %b", strobes(), exp); end
        @(negedge clk); #1;
        exp = {3'd0, 7'b1000000};
        tests++;
        if (strobes() !== exp) begin fails++; $display("FAIL ill_nop_refetch: got %b expected %b", strobes(), exp); end
`endif
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        bus.instr = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        test_reset();
        test_addi();
        test_lui();
        test_alu_decode();
        test_store_wait();
        test_load_boundary();
        test_load_timeout();
        test_hold_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
